shared_reg_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for one shared W-bit register built from DFlipFlop cells.
//   N requesters compete for write access to the register.
//   The block grants one requester at a time, loads that requester's data into the register, and returns an ack pulse.

---
 rtl/shared_reg_arbiter.sv | 111 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer for one shared W-bit register.
// N requesters compete; the winner's data word is loaded into q and the
// winner receives a one-cycle ack. A grant is held off until the winning
// requester drops its request, so there is no preemption.
//
// state | meaning
// IDLE  | no owner; arbitrate among active requests
// GRANT | gnt asserted to sel for one cycle; write on next edge if still requested
// WAIT  | write done (ack on first cycle); hold until req[sel] falls
module shared_reg_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           c,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic           busy
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] sel, sel_nxt;
    logic [SW-1:0] last, last_nxt;
    logic [N-1:0]  gnt_nxt, ack_nxt;
    logic [W-1:0]  q_nxt;
    logic          found;
    logic [SW-1:0] pick;

    // Round-robin search starting just after the last requester that completed a write
    always_comb begin
        found = 1'b0;
        pick  = last;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last) + k) % N]) begin
                found = 1'b1;
                pick  = SW'((int'(last) + k) % N);
            end
        end
    end

    // Next-state and next-output logic; gnt and ack default low so each is a single-cycle pulse
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        gnt_nxt   = '0;
        ack_nxt   = '0;
        q_nxt     = q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = GRANT;
                    sel_nxt       = pick;
                    gnt_nxt[pick] = 1'b1;
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    q_nxt        = wdata[sel*W +: W];
                    ack_nxt[sel] = 1'b1;
                    last_nxt     = sel;
                    state_nxt    = WAIT;
                end else begin
                    // Requester withdrew: abort without touching q or the pointer
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (!req[sel]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge c) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            last  <= SW'(N - 1);
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
            q     <= q_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           c = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;

    int errors = 0;
    int checks = 0;

    // Model: who currently owns the register (or -1), whether the owner is
    // still only offered a grant, and the round-robin history.
    int           m_owner;
    bit           m_offered;
    int           m_last;
    logic [N-1:0] m_gnt, m_ack;
    logic [W-1:0] m_q;

    shared_reg_arbiter #(.N(N), .W(W)) dut (
        .c     (c),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    always #5 c = ~c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the spec rules to the inputs present at this clock edge
    task automatic model_edge();
        int word;
        m_ack = '0;
        m_gnt = '0;
        if (reset) begin
            m_owner   = -1;
            m_offered = 0;
            m_last    = N - 1;
            m_q       = '0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
                end
                m_offered        = 1;
                m_gnt[m_owner]   = 1'b1;
            end
        end else if (m_offered) begin
            m_offered = 0;
            if (req[m_owner]) begin
                word           = m_owner;
                m_q            = wdata[word*W +: W];
                m_ack[m_owner] = 1'b1;
                m_last         = m_owner;
            end else begin
                m_owner = -1;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end
    endtask

    // One clock: update the model at the edge, then compare all outputs
    task automatic step();
        @(posedge c);
        model_edge();
        #1;
        chk("gnt",  gnt,  m_gnt);
        chk("ack",  ack,  m_ack);
        chk("q",    q,    m_q);
        chk("busy", busy, (m_owner >= 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int grants[$];
        int exp_order[6];
        int cyc;

        reset     = 1'b1;
        req       = '0;
        wdata     = '0;
        m_owner   = -1;
        m_offered = 0;
        m_last    = N - 1;
        m_gnt     = '0;
        m_ack     = '0;
        m_q       = '0;

        // Reset held for two edges with every requester active
        req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t1_gnt", gnt, 4'b0000);
            chk("t1_ack", ack, 4'b0000);
            chk("t1_busy", busy, 1'b0);
            chk("t1_q", q, 4'h0);
        end
        reset = 1'b0;
        req   = '0;
        step();

        // Single write from requester 2
        req = 4'b0100;
        wdata[11:8] = 4'hA;
        step();
        chk("t2_gnt", gnt, 4'b0100);
        chk("t2_busy", busy, 1'b1);
        step();
        chk("t2_ack", ack, 4'b0100);
        chk("t2_q", q, 4'hA);
        step();
        chk("t2_ack_off", ack, 4'b0000);
        chk("t2_busy_wait", busy, 1'b1);
        req = 4'b0000;
        step();
        chk("t2_idle", busy, 1'b0);

        // Fairness: everyone requesting, each drops for one cycle after its ack
        do_reset();
        req = 4'b1111;
        cyc = 0;
        while (grants.size() < 6 && cyc < 100) begin
            step();
            cyc++;
            for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
            if (ack != 0) req = 4'b1111 & ~ack;
            else req = 4'b1111;
        end
        chk("t3_grant_count", grants.size(), 6);
        exp_order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("t3_order", grants[i], exp_order[i]);

        // Withdraw during GRANT leaves q and pointer unchanged
        do_reset();
        wdata = 16'h7777;
        req   = 4'b0010;
        step();
        chk("t4_gnt", gnt, 4'b0010);
        req = 4'b0000;
        step();
        chk("t4_ack", ack, 4'b0000);
        chk("t4_q", q, 4'h0);
        chk("t4_busy", busy, 1'b0);
        req = 4'b1010;
        step();
        chk("t4_regrant", gnt, 4'b0010);

        // Hold-off: owner keeps request, another request waits
        do_reset();
        req = 4'b0100;
        wdata[11:8] = 4'h3;
        step();
        step();
        chk("t5_ack", ack, 4'b0100);
        req = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_busy", busy, 1'b1);
            chk("t5_gnt", gnt, 4'b0000);
        end
        req = 4'b1000;
        step();
        chk("t5_release", busy, 1'b0);
        step();
        chk("t5_next", gnt, 4'b1000);

        // Reset while in WAIT with q=5
        do_reset();
        req = 4'b0001;
        wdata[3:0] = 4'h5;
        step();
        step();
        chk("t6_q5", q, 4'h5);
        chk("t6_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        chk("t6_q", q, 4'h0);
        chk("t6_ack", ack, 4'b0000);
        chk("t6_busy0", busy, 1'b0);
        reset = 1'b0;
        req = 4'b0110;
        step();
        chk("t6_first", gnt, 4'b0010);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            wdata = 16'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
